// File: rtl/pxie_pkg.sv
// Shared PXIe definitions: header constants, the read-engine state type and a
// helper that builds the readback header word.
package pxie_pkg;

  localparam logic [15:0] PXIE_HDR_SYNC    = 16'heb9c;
  localparam logic [15:0] PXIE_CMD_READCFG = 16'h1010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } c2h_state_t;

  function automatic logic [127:0] c2h_header(input logic [15:0] addr, input logic [15:0] len);
    return {PXIE_HDR_SYNC, PXIE_CMD_READCFG, addr, len, 64'h0};
  endfunction

endpackage

// File: rtl/pxie_sync_fifo.sv
// Show-ahead synchronous FIFO: data_o always presents the oldest entry while
// the FIFO is not empty. Pushes when full and pops when empty are ignored.
module pxie_sync_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pxie_c2h_read_engine.sv
// Card-to-host read engine: emits a header word, then streams len RAM words
// to the PXIe TX path with full valid/ready backpressure.
module pxie_c2h_read_engine
  import pxie_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 128,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              I_PXIE_CLK,
  input  logic              I_Rst,
  input  logic [ADDR_W-1:0] I_c2h_addr,
  input  logic [15:0]       I_c2h_len,
  input  logic              I_c2h_en,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic              O_ram_rden,
  input  logic [DATA_W-1:0] I_ram_data,
  output logic [DATA_W-1:0] O_tx_data,
  output logic              O_tx_vld,
  output logic              O_tx_last,
  input  logic              I_tx_rdy,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_req_drop
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  c2h_state_t         state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        len_q, remaining_q, sent_q;
  logic               busy_q, done_q, drop_q;
  logic [RAM_LAT-1:0] vld_sr_q;
  logic [CNT_W-1:0]   outst_q;

  logic [DATA_W-1:0]  fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic               data_phase, hdr_vld, data_vld, ram_rden;
  logic [CNT_W:0]     credit_used;

  assign data_phase  = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign hdr_vld     = (state_q == ST_HEAD);
  assign data_vld    = data_phase && !fifo_empty;
  assign fifo_push   = vld_sr_q[RAM_LAT-1];
  assign fifo_pop    = data_vld && I_tx_rdy;

  // Reads in flight count against FIFO space so returning data always fits.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
  assign ram_rden    = (state_q == ST_READ) && (remaining_q != '0) && !fifo_full &&
                       (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

  assign O_ram_addr  = addr_q;
  assign O_ram_rden  = ram_rden;
  assign O_tx_vld    = hdr_vld || data_vld;
  assign O_tx_last   = hdr_vld ? (len_q == '0) : (data_vld && (sent_q == len_q - 16'd1));
  assign O_tx_data   = hdr_vld  ? DATA_W'(c2h_header(16'(addr_q), len_q)) :
                       data_vld ? fifo_head : '0;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_req_drop  = drop_q;

  pxie_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (I_PXIE_CLK),
    .rst_i   (I_Rst),
    .push_i  (fifo_push),
    .data_i  (I_ram_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge I_PXIE_CLK) begin
    if (I_Rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      vld_sr_q    <= '0;
      outst_q     <= '0;
    end else begin
      drop_q   <= I_c2h_en && (state_q != ST_IDLE);
      done_q   <= 1'b0;
      vld_sr_q <= RAM_LAT'({vld_sr_q, ram_rden});

      case ({ram_rden, fifo_push})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase

      if (fifo_pop) sent_q <= sent_q + 16'd1;

      case (state_q)
        ST_IDLE: begin
          if (I_c2h_en) begin
            addr_q      <= I_c2h_addr;
            len_q       <= I_c2h_len;
            remaining_q <= I_c2h_len;
            sent_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (I_tx_rdy) begin
            if (len_q == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (ram_rden) begin
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Finish in the cycle of the final handshake so O_done follows it directly.
          if ((outst_q == '0) && (fifo_empty || (fifo_pop && (fifo_count == CNT_W'(1))))) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pxie_c2h_read_engine.sv
// Scoreboard bench for pxie_c2h_read_engine: four DUT lanes (RAM_LAT 1..4)
// share stimulus; each lane's monitor walks the shared expected queues.
module tb_pxie_c2h_read_engine;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        c2hEn;
  logic        txRdy;
  logic [15:0] c2hAddr;
  logic [15:0] c2hLen;
  logic        rstSampled = 1'b0;

  int rdyMode = 0;
  int errors  = 0;
  int checks  = 0;
  int expDone = 0;
  int expDrop = 0;

  beat_t       expBeats[$];
  logic [15:0] expAddrs[$];

  always #5 clk = ~clk;

  // Remembers whether the last active edge saw reset, so monitors know outputs must be idle.
  always @(posedge clk) rstSampled <= rst;

  task automatic checkOutput(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Downstream ready: always high, 30% duty, or 50% duty.
  initial begin
    txRdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdyMode)
        0:       txRdy = 1'b1;
        1:       txRdy = ($urandom_range(0, 99) < 30);
        default: txRdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int LAT = g + 1;

    logic [15:0]  ramAddr;
    logic         ramRden;
    logic [127:0] ramData;
    logic [127:0] txData;
    logic         txVld, txLast, busy, done, reqDrop;
    logic [15:0]  pipeAddr [LAT];
    int           wordPtr  = 0;
    int           addrPtr  = 0;
    int           doneSeen = 0;
    int           dropSeen = 0;
    logic         stalled    = 1'b0;
    logic         prevLastHs = 1'b0;
    beat_t        held;

    // RAM model: returns its own word address as data, LAT cycles after the read strobe.
    always @(posedge clk) begin
      pipeAddr[0] <= ramAddr;
      for (int k = 1; k < LAT; k++) pipeAddr[k] <= pipeAddr[k-1];
    end
    assign ramData = {112'h0, pipeAddr[LAT-1]};

    pxie_c2h_read_engine #(
      .ADDR_W     (16),
      .DATA_W     (128),
      .RAM_LAT    (LAT),
      .FIFO_DEPTH (8)
    ) dut (
      .I_PXIE_CLK (clk),
      .I_Rst      (rst),
      .I_c2h_addr (c2hAddr),
      .I_c2h_len  (c2hLen),
      .I_c2h_en   (c2hEn),
      .O_ram_addr (ramAddr),
      .O_ram_rden (ramRden),
      .I_ram_data (ramData),
      .O_tx_data  (txData),
      .O_tx_vld   (txVld),
      .O_tx_last  (txLast),
      .I_tx_rdy   (txRdy),
      .O_busy     (busy),
      .O_done     (done),
      .O_req_drop (reqDrop)
    );

    // Monitor: compares reads and handshaken beats against the expected queues.
    always @(negedge clk) begin
      if (rstSampled) begin
        checkOutput($sformatf("lat%0d_reset_ctrl", LAT),
                    {ramAddr, ramRden, txVld, txLast, busy, done, reqDrop}, '0);
        checkOutput($sformatf("lat%0d_reset_data", LAT), {1'b0, txData}, '0);
        wordPtr    <= expBeats.size();
        addrPtr    <= expAddrs.size();
        stalled    <= 1'b0;
        prevLastHs <= 1'b0;
      end else begin
        if (ramRden === 1'b1) begin
          if (addrPtr < expAddrs.size()) begin
            checkOutput($sformatf("lat%0d_rden_addr", LAT), ramAddr, expAddrs[addrPtr]);
            addrPtr <= addrPtr + 1;
          end else begin
            failNow($sformatf("lat%0d_extra_rden", LAT),
                    $sformatf("got read of %h, expected no read", ramAddr));
          end
        end
        if (done === 1'b1) begin
          doneSeen <= doneSeen + 1;
          checkOutput($sformatf("lat%0d_done_after_last", LAT), prevLastHs, 1'b1);
        end
        if (reqDrop === 1'b1) dropSeen <= dropSeen + 1;
        if (stalled) begin
          if (txVld !== 1'b1)
            failNow($sformatf("lat%0d_vld_dropped", LAT), "got vld low during stall, expected held high");
          else
            checkOutput($sformatf("lat%0d_stall_hold", LAT), {txData, txLast}, held);
        end
        prevLastHs <= (txVld === 1'b1) && txRdy && (txLast === 1'b1);
        if (txVld === 1'b1) begin
          if (txRdy) begin
            if (wordPtr < expBeats.size()) begin
              checkOutput($sformatf("lat%0d_beat%0d", LAT, wordPtr), {txData, txLast}, expBeats[wordPtr]);
              wordPtr <= wordPtr + 1;
            end else begin
              failNow($sformatf("lat%0d_extra_beat", LAT),
                      $sformatf("got beat %h, expected none", txData));
            end
            stalled <= 1'b0;
          end else begin
            stalled <= 1'b1;
            held    <= {txData, txLast};
          end
        end else begin
          stalled <= 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] len);
    logic [15:0] a;
    @(posedge clk);
    #1;
    expBeats.push_back(beat_t'{{16'heb9c, 16'h1010, addr, len, 64'h0}, (len == 16'd0)});
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 16'(i);
      expBeats.push_back(beat_t'{{112'h0, a}, (i == int'(len) - 1)});
      expAddrs.push_back(a);
    end
    expDone++;
    c2hAddr = addr;
    c2hLen  = len;
    c2hEn   = 1'b1;
    @(posedge clk);
    #1;
    c2hEn = 1'b0;
  endtask

  task automatic dropRequest(input logic [15:0] addr, input logic [15:0] len);
    @(posedge clk);
    #1;
    expDrop++;
    c2hAddr = addr;
    c2hLen  = len;
    c2hEn   = 1'b1;
    @(posedge clk);
    #1;
    c2hEn = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int cyc = 0;
    repeat (2) @(posedge clk);
    while ((lane[0].busy !== 1'b0 || lane[1].busy !== 1'b0 ||
            lane[2].busy !== 1'b0 || lane[3].busy !== 1'b0) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 3000) failNow(name, "got busy after 3000 cycles, expected idle");
    repeat (2) @(posedge clk);
  endtask

  task automatic checkLane(input string name, input int words, input int addrs, input int dones, input int drops);
    checkOutput({name, "_beats_seen"}, words, expBeats.size());
    checkOutput({name, "_reads_seen"}, addrs, expAddrs.size());
    checkOutput({name, "_done_count"}, dones, expDone);
    checkOutput({name, "_drop_count"}, drops, expDrop);
  endtask

  initial begin
    int start;
    int cyc;

    // Reset held three cycles with random inputs.
    rst     = 1'b1;
    rdyMode = 2;
    c2hEn   = 1'($urandom_range(0, 1));
    c2hAddr = 16'($urandom);
    c2hLen  = 16'($urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
      c2hEn   = 1'($urandom_range(0, 1));
      c2hAddr = 16'($urandom);
      c2hLen  = 16'($urandom);
    end
    rst   = 1'b0;
    c2hEn = 1'b0;
    repeat (3) @(posedge clk);

    rdyMode = 0;
    applyStimulus(16'h0010, 16'd4);
    waitIdle("basic_timeout");

    applyStimulus(16'hfffe, 16'd3);
    waitIdle("wrap_timeout");

    applyStimulus(16'h0042, 16'd0);
    waitIdle("zero_len_timeout");

    applyStimulus(16'h0500, 16'd6);
    repeat (3) @(posedge clk);
    dropRequest(16'h0600, 16'd5);
    waitIdle("drop_timeout");

    rdyMode = 1;
    applyStimulus(16'h0300, 16'd16);
    waitIdle("backpressure_timeout");

    // Abort after the second data word of an 8-word transfer on the RAM_LAT=2 lane.
    rdyMode = 0;
    start   = expBeats.size();
    applyStimulus(16'h0100, 16'd8);
    cyc = 0;
    while (lane[1].wordPtr < start + 3 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 200) failNow("abort_wait_timeout", "got fewer than 2 data words, expected 2");
    #1;
    rst = 1'b1;
    expDone--;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus(16'h0200, 16'd2);
    waitIdle("post_reset_timeout");

    rdyMode = 2;
    applyStimulus(16'h0700, 16'd12);
    waitIdle("random_bp_timeout");

    repeat (2) @(posedge clk);
    checkLane("lat1", lane[0].wordPtr, lane[0].addrPtr, lane[0].doneSeen, lane[0].dropSeen);
    checkLane("lat2", lane[1].wordPtr, lane[1].addrPtr, lane[1].doneSeen, lane[1].dropSeen);
    checkLane("lat3", lane[2].wordPtr, lane[2].addrPtr, lane[2].doneSeen, lane[2].dropSeen);
    checkLane("lat4", lane[3].wordPtr, lane[3].addrPtr, lane[3].doneSeen, lane[3].dropSeen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
